// File: rtl/hawk_axi_rd_arb_if.sv
// Bus bundle for hawk_axi_rd_arb: the requester-side AR/R fan-in/fan-out and the
// shared AXI4 read master port (AR + R channels).
//   master : the arbiter's view (drives m_* AR outputs and req_* R outputs)
//   slave  : the environment's view (requesters plus AXI fabric)
interface hawk_axi_rd_arb_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512
);
  // requester side
  logic [NUM_REQ-1:0]        req_arvalid_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*8-1:0]      req_arlen_i;
  logic [NUM_REQ-1:0]        req_arready_o;
  logic [NUM_REQ-1:0]        req_rvalid_o;
  logic [NUM_REQ-1:0]        req_rready_i;
  logic [DATA_W-1:0]         req_rdata_o;
  logic [1:0]                req_rresp_o;
  logic                      req_rlast_o;
  // AXI read master side
  logic                      m_arvalid_o;
  logic [ADDR_W-1:0]         m_araddr_o;
  logic [7:0]                m_arlen_o;
  logic                      m_arready_i;
  logic                      m_rvalid_i;
  logic [DATA_W-1:0]         m_rdata_i;
  logic [1:0]                m_rresp_i;
  logic                      m_rlast_i;
  logic                      m_rready_o;

  modport master (
    input  req_arvalid_i, req_addr_i, req_arlen_i, req_rready_i,
    input  m_arready_i, m_rvalid_i, m_rdata_i, m_rresp_i, m_rlast_i,
    output req_arready_o, req_rvalid_o, req_rdata_o, req_rresp_o, req_rlast_o,
    output m_arvalid_o, m_araddr_o, m_arlen_o, m_rready_o
  );

  modport slave (
    output req_arvalid_i, req_addr_i, req_arlen_i, req_rready_i,
    output m_arready_i, m_rvalid_i, m_rdata_i, m_rresp_i, m_rlast_i,
    input  req_arready_o, req_rvalid_o, req_rdata_o, req_rresp_o, req_rlast_o,
    input  m_arvalid_o, m_araddr_o, m_arlen_o, m_rready_o
  );
endinterface

// File: rtl/hawk_axi_rd_arb.sv
// hawk_axi_rd_arb: round-robin arbiter sharing one AXI4 read master port among
// NUM_REQ hawk requesters, one outstanding transaction at a time.
// Sequence per transaction: IDLE (grant + capture) -> ADDR (AR beat) -> DATA
// (R beats steered to the grantee until rlast) -> IDLE.
// Optional watchdog: define HAWK_RD_ARB_WDOG_EN to enable the TIMEOUT counter;
// without it timeout_err_o is tied to 0.
module hawk_axi_rd_arb #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  hawk_axi_rd_arb_if.master          bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       busy_o,
  output logic                       len_err_o,
  output logic                       timeout_err_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         beat_cnt_q, beat_cnt_d;
  logic               len_err_q, len_err_d;

  logic               found;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] arready;
  logic [NUM_REQ-1:0] rvalid;
  logic               m_rready;
  logic               m_arvalid;
  logic [DATA_W-1:0]  rdata;
  logic [1:0]         rresp;
  logic               rlast;

  // Round-robin pick: first requesting index after the last grantee, wrapping to 0.
  always_comb begin
    int cand;
    found    = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(last_grant_q) + 1 + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && bus.req_arvalid_i[cand]) begin
        found    = 1'b1;
        pick_idx = IDX_W'(cand);
      end
    end
  end

  // Next-state and output decode for the IDLE/ADDR/DATA sequencer.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    len_err_d    = len_err_q;
    arready      = '0;
    rvalid       = '0;
    m_rready     = 1'b0;
    m_arvalid    = 1'b0;
    rdata        = '0;
    rresp        = 2'b00;
    rlast        = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          // Accept pulse is masked while reset is held so no request is lost.
          arready[pick_idx] = rst_ni;
          grant_d           = pick_idx;
          addr_d            = bus.req_addr_i[pick_idx*ADDR_W +: ADDR_W];
          len_d             = bus.req_arlen_i[pick_idx*8 +: 8];
          state_d           = ADDR;
        end
      end
      ADDR: begin
        m_arvalid = 1'b1;
        if (bus.m_arready_i) begin
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        m_rready        = bus.req_rready_i[grant_q];
        rvalid[grant_q] = bus.m_rvalid_i;
        rdata           = bus.m_rdata_i;
        rresp           = bus.m_rresp_i;
        rlast           = bus.m_rlast_i;
        if (bus.m_rvalid_i && m_rready) begin
          if (bus.m_rlast_i) begin
            // rlast always ends the burst, even when the count disagrees.
            if (beat_cnt_q != len_q) len_err_d = 1'b1;
            beat_cnt_d   = '0;
            last_grant_d = grant_q;
            state_d      = IDLE;
          end else begin
            // Final expected beat arrived without rlast: burst overruns arlen.
            if (beat_cnt_q == len_q) len_err_d = 1'b1;
            if (beat_cnt_q != 8'hFF) beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, captured request and sticky length error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      addr_q       <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      len_err_q    <= len_err_d;
    end
  end

`ifdef HAWK_RD_ARB_WDOG_EN
  localparam int WDOG_W = $clog2(TIMEOUT + 1);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              timeout_err_q, timeout_err_d;

  // Watchdog: counts stalled cycles in ADDR/DATA, cleared by any handshake or IDLE.
  always_comb begin
    wdog_cnt_d    = wdog_cnt_q;
    timeout_err_d = timeout_err_q;
    if (state_q == IDLE) begin
      wdog_cnt_d = '0;
    end else if ((m_arvalid && bus.m_arready_i) || (bus.m_rvalid_i && m_rready)) begin
      wdog_cnt_d = '0;
    end else if (wdog_cnt_q != WDOG_W'(TIMEOUT)) begin
      wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
    end
    if (wdog_cnt_d == WDOG_W'(TIMEOUT)) timeout_err_d = 1'b1;
  end

  // Watchdog counter and sticky timeout flag; the FSM is never forced out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wdog_cnt_q    <= wdog_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err_o = timeout_err_q;
`else
  assign timeout_err_o = 1'b0;
`endif

  assign bus.req_arready_o = arready;
  assign bus.req_rvalid_o  = rvalid;
  assign bus.req_rdata_o   = rdata;
  assign bus.req_rresp_o   = rresp;
  assign bus.req_rlast_o   = rlast;
  assign bus.m_arvalid_o   = m_arvalid;
  assign bus.m_araddr_o    = addr_q;
  assign bus.m_arlen_o     = len_q;
  assign bus.m_rready_o    = m_rready;
  assign grant_id_o        = grant_q;
  assign busy_o            = (state_q != IDLE);
  assign len_err_o         = len_err_q;

endmodule

// File: tb/tb_hawk_axi_rd_arb.sv
// Directed bench for hawk_axi_rd_arb: single transfer, multi-beat with requester
// back-pressure, short-burst length error, reset mid-burst, and round-robin order.
module tb_hawk_axi_rd_arb;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 512;

  logic clk_i;
  logic rst_ni;
  logic [0:0] grant_id_o;
  logic busy_o;
  logic len_err_o;
  logic timeout_err_o;

  int n_cmp;
  int n_err;

  hawk_axi_rd_arb_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  hawk_axi_rd_arb #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .bus          (bus_if.master),
    .grant_id_o   (grant_id_o),
    .busy_o       (busy_o),
    .len_err_o    (len_err_o),
    .timeout_err_o(timeout_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One transaction for requester r; arv is the arvalid mask to present,
  // drop clears bit r after its accept pulse. rlast is raised on beat last_idx.
  task automatic do_txn(input int r, input logic [63:0] addr, input logic [7:0] len,
                        input int last_idx, input logic [1:0] arv, input logic drop);
    logic [1:0] onehot;
    onehot = 2'b01 << r;
    bus_if.req_addr_i[r*ADDR_W +: ADDR_W] = addr;
    bus_if.req_arlen_i[r*8 +: 8]          = len;
    bus_if.req_arvalid_i                  = arv;
    @(negedge clk_i);
    chk("idle_busy", 64'(busy_o), 64'd0);
    chk("ar_pulse", 64'(bus_if.req_arready_o), 64'(onehot));
    tick();
    if (drop) bus_if.req_arvalid_i = arv & ~onehot;
    @(negedge clk_i);
    chk("m_arvalid", 64'(bus_if.m_arvalid_o), 64'd1);
    chk("m_araddr", bus_if.m_araddr_o, addr);
    chk("m_arlen", 64'(bus_if.m_arlen_o), 64'(len));
    chk("grant_id", 64'(grant_id_o), 64'(r));
    tick();
    for (int b = 0; b <= last_idx; b++) begin
      bus_if.m_rvalid_i = 1'b1;
      bus_if.m_rdata_i  = DATA_W'(64'h100 * (r + 1) + b);
      bus_if.m_rlast_i  = (b == last_idx);
      @(negedge clk_i);
      chk("rvalid_o", 64'(bus_if.req_rvalid_o), 64'(onehot));
      chk("rdata_o", bus_if.req_rdata_o[63:0], 64'h100 * (r + 1) + b);
      tick();
    end
    bus_if.m_rvalid_i = 1'b0;
    bus_if.m_rlast_i  = 1'b0;
  endtask

  initial begin
    int beats;
    logic rr1;
    n_cmp = 0;
    n_err = 0;
    rst_ni = 1'b0;
    bus_if.req_arvalid_i = '0;
    bus_if.req_addr_i    = '0;
    bus_if.req_arlen_i   = '0;
    bus_if.req_rready_i  = 2'b11;
    bus_if.m_arready_i   = 1'b1;
    bus_if.m_rvalid_i    = 1'b0;
    bus_if.m_rdata_i     = '0;
    bus_if.m_rresp_i     = 2'b00;
    bus_if.m_rlast_i     = 1'b0;

    // Reset values
    repeat (2) @(negedge clk_i);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_grant", 64'(grant_id_o), 64'd0);
    chk("rst_arvalid", 64'(bus_if.m_arvalid_o), 64'd0);
    chk("rst_len_err", 64'(len_err_o), 64'd0);
    chk("rst_tmo_err", 64'(timeout_err_o), 64'd0);
    chk("rst_rready", 64'(bus_if.m_rready_o), 64'd0);
    rst_ni = 1'b1;
    tick();

    // Single-beat read for req0 at 0x1000
    bus_if.req_addr_i[0 +: ADDR_W] = 64'h1000;
    bus_if.req_arlen_i[0 +: 8]     = 8'd0;
    bus_if.req_arvalid_i           = 2'b01;
    @(negedge clk_i);
    chk("t1_arready", 64'(bus_if.req_arready_o), 64'h1);
    chk("t1_busy0", 64'(busy_o), 64'd0);
    chk("t1_arvalid0", 64'(bus_if.m_arvalid_o), 64'd0);
    tick();
    bus_if.req_arvalid_i = 2'b00;
    @(negedge clk_i);
    chk("t1_arvalid1", 64'(bus_if.m_arvalid_o), 64'd1);
    chk("t1_araddr", bus_if.m_araddr_o, 64'h1000);
    chk("t1_busy1", 64'(busy_o), 64'd1);
    chk("t1_arready_off", 64'(bus_if.req_arready_o), 64'h0);
    chk("t1_rready_addr", 64'(bus_if.m_rready_o), 64'd0);
    tick();
    bus_if.m_rvalid_i = 1'b1;
    bus_if.m_rdata_i  = DATA_W'(64'hAAAA);
    bus_if.m_rresp_i  = 2'b10;
    bus_if.m_rlast_i  = 1'b1;
    @(negedge clk_i);
    chk("t1_rvalid", 64'(bus_if.req_rvalid_o), 64'h1);
    chk("t1_rdata", bus_if.req_rdata_o[63:0], 64'hAAAA);
    chk("t1_rresp", 64'(bus_if.req_rresp_o), 64'h2);
    chk("t1_rlast", 64'(bus_if.req_rlast_o), 64'd1);
    chk("t1_m_rready", 64'(bus_if.m_rready_o), 64'd1);
    tick();
    bus_if.m_rvalid_i = 1'b0;
    bus_if.m_rlast_i  = 1'b0;
    bus_if.m_rresp_i  = 2'b00;
    @(negedge clk_i);
    chk("t1_busy_end", 64'(busy_o), 64'd0);
    chk("t1_rvalid_end", 64'(bus_if.req_rvalid_o), 64'h0);
    chk("t1_len_err", 64'(len_err_o), 64'd0);
    tick();

    // req1, arlen=3, R ready toggling: m_rready follows, 4 beats to req1 only
    bus_if.req_addr_i[ADDR_W +: ADDR_W] = 64'h4000;
    bus_if.req_arlen_i[8 +: 8]          = 8'd3;
    bus_if.req_arvalid_i                = 2'b10;
    @(negedge clk_i);
    chk("t2_arready", 64'(bus_if.req_arready_o), 64'h2);
    tick();
    bus_if.req_arvalid_i = 2'b00;
    @(negedge clk_i);
    chk("t2_araddr", bus_if.m_araddr_o, 64'h4000);
    chk("t2_arlen", 64'(bus_if.m_arlen_o), 64'd3);
    chk("t2_grant", 64'(grant_id_o), 64'd1);
    tick();
    beats = 0;
    for (int c = 0; c < 12 && beats < 4; c++) begin
      rr1 = (c % 2 == 0);
      bus_if.req_rready_i = {rr1, 1'b0};
      bus_if.m_rvalid_i   = 1'b1;
      bus_if.m_rdata_i    = DATA_W'(64'h200 + beats);
      bus_if.m_rlast_i    = (beats == 3);
      @(negedge clk_i);
      chk("t2_m_rready", 64'(bus_if.m_rready_o), 64'(rr1));
      chk("t2_rvalid", 64'(bus_if.req_rvalid_o), 64'h2);
      chk("t2_rdata", bus_if.req_rdata_o[63:0], 64'h200 + beats);
      if (bus_if.req_rvalid_o[1] && bus_if.m_rready_o) beats++;
      tick();
    end
    bus_if.m_rvalid_i   = 1'b0;
    bus_if.m_rlast_i    = 1'b0;
    bus_if.req_rready_i = 2'b11;
    @(negedge clk_i);
    chk("t2_beats", 64'(beats), 64'd4);
    chk("t2_busy_end", 64'(busy_o), 64'd0);
    chk("t2_len_err", 64'(len_err_o), 64'd0);
    tick();

    // req0, arlen=3 but rlast on the third beat: sticky length error
    do_txn(0, 64'h5000, 8'd3, 2, 2'b01, 1'b1);
    @(negedge clk_i);
    chk("t3_busy_end", 64'(busy_o), 64'd0);
    chk("t3_len_err", 64'(len_err_o), 64'd1);
    tick();

    // Next transaction proceeds normally; error stays set
    do_txn(1, 64'h5100, 8'd1, 1, 2'b10, 1'b1);
    @(negedge clk_i);
    chk("t4_busy_end", 64'(busy_o), 64'd0);
    chk("t4_len_err_sticky", 64'(len_err_o), 64'd1);
    tick();

    // Reset asserted during DATA
    bus_if.req_addr_i[ADDR_W +: ADDR_W] = 64'h6000;
    bus_if.req_arlen_i[8 +: 8]          = 8'd3;
    bus_if.req_arvalid_i                = 2'b10;
    @(negedge clk_i);
    chk("t5_arready", 64'(bus_if.req_arready_o), 64'h2);
    tick();
    bus_if.req_arvalid_i = 2'b00;
    tick();
    bus_if.m_rvalid_i = 1'b1;
    bus_if.m_rdata_i  = DATA_W'(64'h77);
    @(negedge clk_i);
    chk("t5_rvalid_pre", 64'(bus_if.req_rvalid_o), 64'h2);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t5_rst_busy", 64'(busy_o), 64'd0);
    chk("t5_rst_rvalid", 64'(bus_if.req_rvalid_o), 64'h0);
    chk("t5_rst_rready", 64'(bus_if.m_rready_o), 64'd0);
    chk("t5_rst_rdata", bus_if.req_rdata_o[63:0], 64'h0);
    chk("t5_rst_len_err", 64'(len_err_o), 64'd0);
    chk("t5_rst_grant", 64'(grant_id_o), 64'd0);
    bus_if.m_rvalid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Both requesters held: round-robin 0,1,0,1 starting with req0
    bus_if.req_addr_i[0 +: ADDR_W]      = 64'h2000;
    bus_if.req_addr_i[ADDR_W +: ADDR_W] = 64'h3000;
    for (int t = 0; t < 4; t++) begin
      do_txn(t % 2, (t % 2 == 0) ? 64'h2000 : 64'h3000, 8'd0, 0, 2'b11, 1'b0);
    end
    bus_if.req_arvalid_i = 2'b00;
    @(negedge clk_i);
    chk("rr_busy_end", 64'(busy_o), 64'd0);
    chk("rr_no_pulse", 64'(bus_if.req_arready_o), 64'h0);
    chk("rr_len_err", 64'(len_err_o), 64'd0);
    chk("rr_tmo_err", 64'(timeout_err_o), 64'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Overall time bound.
  initial begin
    #200000;
    $display("FAIL sim_timeout: got expired expected finish");
    $fatal(1);
  end

endmodule
